fft8_frame_loader: RTL and testbench
====================================

Name: fft8_frame_loader

Overview:
Upstream stage of the 8-point floating-point FFT core. Accepts a serial stream of IEEE-754 single-precision complex samples over a valid/ready handshake. Assembles them into 8-sample frames in a two-bank ping-pong buffer. Presents each complete frame as the parallel A_r/A_i buses the FFT8 core consumes, together with the constant N=8 twiddle buses W_r/W_i.

Parameters:
CHECK_LAST, 1, 1 = enforce in_last framing and flag violations on frame_err; 0 = ignore in_last, frames are every 8 accepted samples.

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  sample valid
in_ready  output  1  loader can accept a sample this cycle
in_re  input  32  sample real part, IEEE-754 single
in_im  input  32  sample imaginary part, IEEE-754 single
in_last  input  1  marks final (8th) sample of a frame
frame_valid  output  1  complete frame present on A_r/A_i
frame_ready  input  1  downstream consumes the frame
A_r  output  256  frame real parts; sample k at bits [32k+31:32k]
A_i  output  256  frame imaginary parts, same packing
W_r  output  128  twiddle real parts, W0..W3 packed like A_r
W_i  output  128  twiddle imaginary parts
frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- State: banks B0/B1, each 8 x (32 re + 32 im) registers; full[1:0]; wr_bank, rd_bank (1 bit each); wr_idx (3 bits).
- Reset (async): storage, full, wr_bank, rd_bank, wr_idx and frame_err all clear to 0. Resulting outputs: in_ready=1, frame_valid=0, A_r=A_i=0. Reset mid-frame discards any partial or full frames.
- in_ready = ~full[wr_bank] (combinational). Accept = in_valid & in_ready.
- On accept: store in_re/in_im at bank[wr_bank][wr_idx].
  - wr_idx<7 and not (CHECK_LAST & in_last): wr_idx increments.
  - wr_idx==7: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- Early last (CHECK_LAST=1, in_last=1, wr_idx<7): the partial frame is abandoned, including this sample. wr_idx<=0, no full flag set, frame_err=1 for one cycle.
- Missing last (CHECK_LAST=1, wr_idx==7, in_last=0): the frame is still committed and frame_err pulses for one cycle.
- frame_valid = full[rd_bank]. A_r/A_i are driven by a combinational mux from bank[rd_bank] storage. They hold stable while frame_valid=1 and frame_ready=0.
- On frame_valid & frame_ready: full[rd_bank]<=0 and rd_bank toggles.
- Completing a write into one bank and a read out of the other in the same cycle is legal; each full flag updates independently. Writer and reader never target the same bank while it is full.
- Latency: the 8th sample accepted at edge t gives frame_valid=1 from edge t (visible in cycle t+1).
- Throughput: with frame_ready held at 1, in_ready never drops, giving 1 sample/cycle and one frame per 8 cycles.
- Backpressure: both banks full means in_ready=0, and no sample is lost. in_ready rises the cycle after the reading bank is consumed.
- With frame_valid=0, A_r/A_i show the stale contents of bank[rd_bank]; downstream must ignore them.
- Samples are stored bit-exact; no arithmetic and no NaN/denormal handling.
- Twiddles W_k = exp(-j2πk/8) are constant outputs, unaffected by reset:
  - W_r = {BF3504F3, 00000000, 3F3504F3, 3F800000}
  - W_i = {BF3504F3, BF800000, BF3504F3, 00000000}
  - Both are listed W3..W0, MSB first.

Test Plan:
- Reset, then stream samples k=0..7 with re = float(k) (0x00000000, 0x3F800000, …, 0x40E00000), im=0, in_last on k=7, frame_ready=1 → frame_valid high for exactly one cycle after the 8th accept; A_r[63:32]=3F800000 and A_r[255:224]=40E00000; frame_err never pulses.
- Hold frame_ready=0 and send 16 samples → in_ready drops after the 16th accept and the 17th sample stalls. Raise frame_ready → frames come out in order (samples 0-7, then 8-15), and in_ready returns the cycle after the first consume.
- Continuous 3-frame stream with frame_ready=1 → in_ready stays 1 and a frame emerges every 8 cycles.
- CHECK_LAST=1, in_last asserted on the 5th sample → frame_err is a 1-cycle pulse and no frame is produced. The next 8 samples form a clean frame, with their first sample at A_r[31:0].
- Assert rst with 4 samples pending and one full bank → frame_valid=0, in_ready=1 and A_r=0 immediately. A following 8-sample frame packs from index 0.
- Check W_r/W_i equal the constants above, both during and after reset.

Source files
------------

// File: rtl/fft8_frame_loader_if.sv
// Handshake and frame buses between the sample source, the frame loader and the FFT8 core.
// The master side drives samples in and accepts frames out; the slave side is the loader.
interface fft8_frame_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_re;
  logic [31:0]  in_im;
  logic         in_last;
  logic         frame_valid;
  logic         frame_ready;
  logic [255:0] A_r;
  logic [255:0] A_i;
  logic [127:0] W_r;
  logic [127:0] W_i;
  logic         frame_err;

  modport master (
    output in_valid, in_re, in_im, in_last, frame_ready,
    input  in_ready, frame_valid, A_r, A_i, W_r, W_i, frame_err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, frame_ready,
    output in_ready, frame_valid, A_r, A_i, W_r, W_i, frame_err
  );
endinterface

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel loader for the 8-point FFT: packs complex samples into a two-bank
// ping-pong buffer and presents each full bank as A_r/A_i with the constant N=8 twiddles.
module fft8_frame_loader #(
  parameter bit CHECK_LAST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  fft8_frame_loader_if.slave bus
);
  localparam logic [127:0] TW_RE = {32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
  localparam logic [127:0] TW_IM = {32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};

  logic [31:0] re_mem [2][8];
  logic [31:0] im_mem [2][8];
  logic [1:0]  full;
  logic [1:0]  full_next;
  logic        wr_bank;
  logic        rd_bank;
  logic [2:0]  wr_idx;
  logic        err_q;

  logic accept;
  logic consume;
  logic idx_last;
  logic early_last;
  logic missing_last;

  assign bus.in_ready    = ~full[wr_bank];
  assign bus.frame_valid = full[rd_bank];
  assign bus.frame_err   = err_q;
  assign bus.W_r         = TW_RE;
  assign bus.W_i         = TW_IM;

  assign accept       = bus.in_valid & ~full[wr_bank];
  assign consume      = full[rd_bank] & bus.frame_ready;
  assign idx_last     = (wr_idx == 3'd7);
  assign early_last   = CHECK_LAST && bus.in_last && !idx_last;
  assign missing_last = CHECK_LAST && !bus.in_last && idx_last;

  // Read and write banks differ whenever both flags can change, so the updates never collide.
  always_comb begin
    full_next = full;
    if (consume) full_next[rd_bank] = 1'b0;
    if (accept && idx_last) full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          re_mem[1'(b)][3'(k)] <= '0;
          im_mem[1'(b)][3'(k)] <= '0;
        end
      end
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      err_q   <= 1'b0;
    end else begin
      full  <= full_next;
      err_q <= accept && (early_last || missing_last);
      if (accept) begin
        re_mem[wr_bank][wr_idx] <= bus.in_re;
        im_mem[wr_bank][wr_idx] <= bus.in_im;
        if (idx_last) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else if (early_last) begin
          wr_idx  <= '0;
        end else begin
          wr_idx  <= wr_idx + 3'd1;
        end
      end
      if (consume) rd_bank <= ~rd_bank;
    end
  end

  always_comb begin
    bus.A_r = '0;
    bus.A_i = '0;
    for (int k = 0; k < 8; k++) begin
      bus.A_r[32*k +: 32] = re_mem[rd_bank][3'(k)];
      bus.A_i[32*k +: 32] = im_mem[rd_bank][3'(k)];
    end
  end
endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed bench for fft8_frame_loader: framing, backpressure, early/missing last,
// mid-stream reset and the constant twiddle outputs.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%h expected=%h", tag, (obs), (exp)); \
    end \
  end

module tb_fft8_frame_loader;
  localparam logic [127:0] EXP_WR = {32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
  localparam logic [127:0] EXP_WI = {32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   stalls = 0;
  logic [31:0]  tab [16];
  logic [255:0] exp_r;
  logic [255:0] exp_i;
  int   t_prev;

  fft8_frame_loader_if bus ();

  fft8_frame_loader #(.CHECK_LAST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

  // Holds the sample until accepted (bounded), then returns #1 after the accepting edge.
  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    int w;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    bus.in_last  = last;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    stalls += w;
    if (w >= 50) begin
      errors++;
      $display("FAIL send_timeout observed=stalled expected=accept");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tab = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
            32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
            32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
    bus.in_valid    = 1'b0;
    bus.in_re       = '0;
    bus.in_im       = '0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b1;

    // Reset state
    #12;
    `CHK("rst_in_ready", bus.in_ready, 1'b1)
    `CHK("rst_frame_valid", bus.frame_valid, 1'b0)
    `CHK("rst_A_r", bus.A_r, 256'h0)
    `CHK("rst_frame_err", bus.frame_err, 1'b0)
    `CHK("rst_W_r", bus.W_r, EXP_WR)
    `CHK("rst_W_i", bus.W_i, EXP_WI)
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame, re = float(k)
    for (int k = 0; k < 7; k++) send(tab[k], 32'h10000000 + k, 1'b0);
    `CHK("f1_not_valid_early", bus.frame_valid, 1'b0)
    send(tab[7], 32'h10000007, 1'b1);
    `CHK("f1_valid", bus.frame_valid, 1'b1)
    `CHK("f1_A_r_1", bus.A_r[63:32], 32'h3F800000)
    `CHK("f1_A_r_7", bus.A_r[255:224], 32'h40E00000)
    `CHK("f1_A_i_0", bus.A_i[31:0], 32'h10000000)
    idle(1);
    `CHK("f1_valid_one_cycle", bus.frame_valid, 1'b0)
    `CHK("f1_no_err", err_cnt, 0)

    // Backpressure: two frames stored, 17th sample stalls
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(tab[k], 32'h20000000 + k, (k % 8) == 7);
    `CHK("bp_in_ready_low", bus.in_ready, 1'b0)
    `CHK("bp_valid", bus.frame_valid, 1'b1)
    bus.in_valid = 1'b1;
    bus.in_re    = 32'h42000000;
    idle(2);
    `CHK("bp_stall_ready", bus.in_ready, 1'b0)
    `CHK("bp_hold_A_r0", bus.A_r[31:0], tab[0])
    `CHK("bp_hold_A_r7", bus.A_r[255:224], tab[7])
    bus.in_valid    = 1'b0;
    bus.frame_ready = 1'b1;
    idle(1);
    `CHK("bp_ready_back", bus.in_ready, 1'b1)
    `CHK("bp_second_valid", bus.frame_valid, 1'b1)
    `CHK("bp_second_A_r0", bus.A_r[31:0], tab[8])
    `CHK("bp_second_A_r7", bus.A_r[255:224], tab[15])
    `CHK("bp_second_A_i3", bus.A_i[127:96], 32'h2000000B)
    idle(1);
    `CHK("bp_drained", bus.frame_valid, 1'b0)

    // Continuous three-frame stream
    stalls = 0;
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        send(32'h30000000 + f * 16 + k, 32'h0, k == 7);
        if (k == 0 && f > 0) `CHK("cs_prev_consumed", bus.frame_valid, 1'b0)
      end
      `CHK("cs_valid", bus.frame_valid, 1'b1)
      `CHK("cs_first", bus.A_r[31:0], 32'h30000000 + f * 16)
      if (f > 0) `CHK("cs_period", cyc - t_prev, 8)
      t_prev = cyc;
    end
    `CHK("cs_no_stall", stalls, 0)
    idle(1);

    // Early last on 5th sample abandons the partial frame
    for (int k = 0; k < 4; k++) send(32'h7F000000 + k, 32'h0, 1'b0);
    send(32'h7F000004, 32'h0, 1'b1);
    `CHK("el_err_pulse", bus.frame_err, 1'b1)
    `CHK("el_no_frame", bus.frame_valid, 1'b0)
    idle(1);
    `CHK("el_err_one_cycle", bus.frame_err, 1'b0)
    `CHK("el_err_count", err_cnt, 1)
    for (int k = 0; k < 7; k++) send(tab[k], 32'h0, 1'b0);
    `CHK("el_clean_not_early", bus.frame_valid, 1'b0)
    send(tab[7], 32'h0, 1'b1);
    `CHK("el_clean_valid", bus.frame_valid, 1'b1)
    `CHK("el_clean_A_r0", bus.A_r[31:0], tab[0])
    `CHK("el_clean_A_r7", bus.A_r[255:224], tab[7])
    `CHK("el_clean_no_err", err_cnt, 1)
    idle(1);

    // Missing last still commits the frame with an error pulse
    for (int k = 0; k < 8; k++) send(tab[8 + k], 32'h0, 1'b0);
    `CHK("ml_err_pulse", bus.frame_err, 1'b1)
    `CHK("ml_valid", bus.frame_valid, 1'b1)
    `CHK("ml_A_r7", bus.A_r[255:224], tab[15])
    idle(1);
    `CHK("ml_err_count", err_cnt, 2)

    // Reset with one full bank and four pending samples
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(tab[k], 32'h0, k == 7);
    for (int k = 0; k < 4; k++) send(tab[12 + k], 32'h0, 1'b0);
    `CHK("mr_pre_valid", bus.frame_valid, 1'b1)
    #2;
    rst = 1'b1;
    #1;
    `CHK("mr_valid_cleared", bus.frame_valid, 1'b0)
    `CHK("mr_ready", bus.in_ready, 1'b1)
    `CHK("mr_A_r", bus.A_r, 256'h0)
    `CHK("mr_A_i", bus.A_i, 256'h0)
    `CHK("mr_W_r", bus.W_r, EXP_WR)
    `CHK("mr_W_i", bus.W_i, EXP_WI)
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_r[32*k +: 32] = tab[8 + k];
      exp_i[32*k +: 32] = 32'h50000000 + k;
    end
    for (int k = 0; k < 8; k++) send(tab[8 + k], 32'h50000000 + k, k == 7);
    `CHK("mr_frame_valid", bus.frame_valid, 1'b1)
    `CHK("mr_frame_A_r", bus.A_r, exp_r)
    `CHK("mr_frame_A_i", bus.A_i, exp_i)
    `CHK("post_W_r", bus.W_r, EXP_WR)
    `CHK("post_W_i", bus.W_i, EXP_WI)
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
